// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB-to-mem8KB access controller.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    RESP
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Wide enough to hold RD_LAT_MAX itself.
  localparam int CNT_W = $clog2(RD_LAT_MAX) + 1;

endpackage : apb_mem_pkg

// File: rtl/apb_mem_ctrl.sv
// APB3 slave that turns each setup/access pair into a single mem8KB cs pulse,
// inserts fixed wait states and flags out-of-array addresses with PSLVERR.
module apb_mem_ctrl
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int PADDR_WIDTH = 12,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [PADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]  pwdata,
  output logic [DATA_WIDTH-1:0]  prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   mem_cs,
  output logic                   mem_wr_rd_n,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata
);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("apb_mem_ctrl: RD_LAT must be within 1..4");
    end
  endgenerate

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic                  r_mem_cs;
  logic                  r_mem_wr_rd_n;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic w_setup;
  logic w_in_range;

  assign w_setup = psel & ~penable;

  generate
    if (PADDR_WIDTH > ADDR_WIDTH) begin : g_range
      assign w_in_range = (paddr[PADDR_WIDTH-1:ADDR_WIDTH] == '0);
    end else begin : g_full
      assign w_in_range = 1'b1;
    end
  endgenerate

  // mem_addr/mem_wdata/mem_wr_rd_n double as the latched APB request; they are
  // only reloaded on an accepted in-range setup and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_prdata      <= '0;
      r_pready      <= 1'b0;
      r_pslverr     <= 1'b0;
      r_mem_cs      <= 1'b0;
      r_mem_wr_rd_n <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      // NOTE: non-blocking default makes cs a one-cycle pulse; any branch below
      // that sets it overrides this, and every state reads pre-edge values.
      r_mem_cs <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          if (w_setup) begin
            if (w_in_range) begin
              r_mem_cs      <= 1'b1;
              r_mem_wr_rd_n <= pwrite;
              r_mem_addr    <= paddr[ADDR_WIDTH-1:0];
              r_mem_wdata   <= pwdata;
              r_state       <= ISSUE;
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_prdata  <= '0;
              r_state   <= RESP;
            end
          end
        end

        ISSUE: begin
          if (!psel) begin
            r_state <= IDLE;
          end else if (r_mem_wr_rd_n) begin
            r_pready <= 1'b1;
            r_state  <= RESP;
          end else begin
            r_cnt   <= CNT_W'(RD_LAT);
            r_state <= RDWAIT;
          end
        end

        RDWAIT: begin
          if (!psel) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            r_prdata <= mem_rdata;
            r_pready <= 1'b1;
            r_state  <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        RESP: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_state   <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign prdata      = r_prdata;
  assign pready      = r_pready;
  assign pslverr     = r_pslverr;
  assign mem_cs      = r_mem_cs;
  assign mem_wr_rd_n = r_mem_wr_rd_n;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule : apb_mem_ctrl
